beta_pipe_ctrl: RTL and testbench

- Pipeline Control Unit: the upstream end of the `pip_stall_i` / `pip_flush_i` interface used by every inter-stage pipeline register (fetch→decode, decode→execute, execute→memory) and by the PC register.
- Detects load-use hazards, multi-cycle execute penalties, memory wait, taken branches and exceptions.
- Resolves these by priority and drives one stall and one flush per pipeline register.
- Holds a small FSM plus a down-counter for penalty and trap-flush sequencing.

---
 rtl/beta_pipe_ctrl.sv | 111 +++++++++++
 tb/tb_beta_pipe_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/beta_pipe_ctrl.sv
// beta_pipe_ctrl: pipeline control unit driving stall/flush for PC and inter-stage pipes
// Inputs : clk_i, rstn_i (async active-low), new-instruction/penalty info from execute,
//          decode rs1/rs2 and execute rd/is_load for load-use detection,
//          branch_taken, mem_busy, exception requests.
// Outputs: pc_stall, per-pipe stall/flush (if_dec, dec_exe, exe_mem), trap_ack pulse,
//          state (0 RUN, 1 PENALTY, 2 TRAP) for debug.
module beta_pipe_ctrl #(
    parameter int FlushCycles = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       pcu_new_instr_i,
    input  logic [1:0] pcu_penality_i,
    input  logic [4:0] pcu_dec_rs1_addr_i,
    input  logic [4:0] pcu_dec_rs2_addr_i,
    input  logic [4:0] pcu_exe_rd_addr_i,
    input  logic       pcu_exe_is_load_i,
    input  logic       pcu_branch_taken_i,
    input  logic       pcu_mem_busy_i,
    input  logic       pcu_exception_i,
    output logic       pcu_pc_stall_o,
    output logic       pcu_if_dec_stall_o,
    output logic       pcu_if_dec_flush_o,
    output logic       pcu_dec_exe_stall_o,
    output logic       pcu_dec_exe_flush_o,
    output logic       pcu_exe_mem_stall_o,
    output logic       pcu_exe_mem_flush_o,
    output logic       pcu_trap_ack_o,
    output logic [1:0] pcu_state_o
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] PEN  = 2'd1;
    localparam logic [1:0] TRAP = 2'd2;
    logic [1:0] state, state_nxt, cnt, cnt_nxt;
    logic trap_req, load_use, pen_start;
    // The request cycle is itself the first flush cycle, so TRAP holds FlushCycles-1 more.
    assign trap_req  = pcu_exception_i && state != TRAP;
    assign load_use  = pcu_exe_is_load_i && pcu_exe_rd_addr_i != 5'd0 &&
                       (pcu_exe_rd_addr_i == pcu_dec_rs1_addr_i ||
                        pcu_exe_rd_addr_i == pcu_dec_rs2_addr_i);
    assign pen_start = state == RUN && pcu_new_instr_i && pcu_penality_i != 2'd0;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == TRAP) begin
            if (cnt <= 2'd1) begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end else begin
                cnt_nxt = cnt - 2'd1;
            end
        end else if (trap_req) begin
            state_nxt = (FlushCycles > 1) ? TRAP : RUN;
            cnt_nxt   = (FlushCycles > 1) ? 2'(FlushCycles - 1) : 2'd0;
        end else if (pcu_mem_busy_i) begin
            state_nxt = state;
        end else if (state == PEN) begin
            state_nxt = (cnt == 2'd0) ? RUN : PEN;
            cnt_nxt   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end else if (!pcu_branch_taken_i && pen_start && pcu_penality_i > 2'd1) begin
            // Detection cycle counts as stall 1, so PENALTY covers the remaining N-1.
            state_nxt = PEN;
            cnt_nxt   = pcu_penality_i - 2'd2;
        end
    end
    always_comb begin
        pcu_pc_stall_o      = 1'b0;
        pcu_if_dec_stall_o  = 1'b0;
        pcu_if_dec_flush_o  = 1'b0;
        pcu_dec_exe_stall_o = 1'b0;
        pcu_dec_exe_flush_o = 1'b0;
        pcu_exe_mem_stall_o = 1'b0;
        pcu_exe_mem_flush_o = 1'b0;
        pcu_trap_ack_o      = 1'b0;
        pcu_state_o         = rstn_i ? state : RUN;
        if (!rstn_i) begin
            pcu_trap_ack_o = 1'b0;
        end else if (state == TRAP || trap_req) begin
            pcu_if_dec_flush_o  = 1'b1;
            pcu_dec_exe_flush_o = 1'b1;
            pcu_exe_mem_flush_o = 1'b1;
            pcu_trap_ack_o      = trap_req;
        end else if (pcu_mem_busy_i) begin
            pcu_pc_stall_o      = 1'b1;
            pcu_if_dec_stall_o  = 1'b1;
            pcu_dec_exe_stall_o = 1'b1;
            pcu_exe_mem_stall_o = 1'b1;
        end else if (state == PEN || (!pcu_branch_taken_i && pen_start)) begin
            pcu_pc_stall_o      = 1'b1;
            pcu_if_dec_stall_o  = 1'b1;
            pcu_dec_exe_stall_o = 1'b1;
            pcu_exe_mem_flush_o = 1'b1;
        end else if (pcu_branch_taken_i) begin
            pcu_if_dec_flush_o  = 1'b1;
            pcu_dec_exe_flush_o = 1'b1;
        end else if (load_use) begin
            pcu_pc_stall_o      = 1'b1;
            pcu_if_dec_stall_o  = 1'b1;
            pcu_dec_exe_flush_o = 1'b1;
        end
    end
endmodule

// File: tb/tb_beta_pipe_ctrl.sv
// tb_beta_pipe_ctrl: directed self-checking bench for beta_pipe_ctrl
module tb_beta_pipe_ctrl;
    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       new_instr = 1'b0, is_load = 1'b0, br = 1'b0, busy = 1'b0, exc = 1'b0;
    logic [1:0] pen = 2'd0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       pc_s, id_s, id_f, de_s, de_f, em_s, em_f, ack;
    logic [1:0] st;
    int         errors = 0, checks = 0;
    // Observation order: pc_s id_s id_f de_s de_f em_s em_f ack state[1:0]
    localparam logic [9:0] IDLE    = 10'b0000000_0_00;
    localparam logic [9:0] LU      = 10'b1100100_0_00;
    localparam logic [9:0] BR      = 10'b0010100_0_00;
    localparam logic [9:0] PEN0    = 10'b1101001_0_00;
    localparam logic [9:0] PEN1    = 10'b1101001_0_01;
    localparam logic [9:0] BUSY0   = 10'b1101010_0_00;
    localparam logic [9:0] BUSY1   = 10'b1101010_0_01;
    localparam logic [9:0] ACK0    = 10'b0010101_1_00;
    localparam logic [9:0] ACK1    = 10'b0010101_1_01;
    localparam logic [9:0] TRAPST  = 10'b0010101_0_10;
    beta_pipe_ctrl #(.FlushCycles(2)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .pcu_new_instr_i(new_instr), .pcu_penality_i(pen),
        .pcu_dec_rs1_addr_i(rs1), .pcu_dec_rs2_addr_i(rs2),
        .pcu_exe_rd_addr_i(rd), .pcu_exe_is_load_i(is_load),
        .pcu_branch_taken_i(br), .pcu_mem_busy_i(busy), .pcu_exception_i(exc),
        .pcu_pc_stall_o(pc_s), .pcu_if_dec_stall_o(id_s), .pcu_if_dec_flush_o(id_f),
        .pcu_dec_exe_stall_o(de_s), .pcu_dec_exe_flush_o(de_f),
        .pcu_exe_mem_stall_o(em_s), .pcu_exe_mem_flush_o(em_f),
        .pcu_trap_ack_o(ack), .pcu_state_o(st)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {pc_s, id_s, id_f, de_s, de_f, em_s, em_f, ack, st};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic ni, input logic [1:0] p, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] d, input logic ld, input logic b, input logic mb, input logic ex);
        new_instr = ni; pen = p; rs1 = a1; rs2 = a2; rd = d;
        is_load = ld; br = b; busy = mb; exc = ex;
    endtask
    task automatic cyc(input string tag, input logic ni, input logic [1:0] p, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] d, input logic ld, input logic b,
                       input logic mb, input logic ex, input logic [9:0] exp);
        @(negedge clk_i);
        drive(ni, p, a1, a2, d, ld, b, mb, ex);
        #1;
        chk(tag, exp);
    endtask
    initial begin
        drive(1'b1, 2'd3, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        #2 chk("reset_held_a", IDLE);
        @(posedge clk_i); #1 chk("reset_held_b", IDLE);
        @(negedge clk_i);
        drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn_i = 1'b1;
        for (int i = 0; i < 10; i++) cyc("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("load_use_rs2", 0, 0, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, LU);
        cyc("load_use_gone", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("load_use_rs1", 0, 0, 5'd7, 5'd2, 5'd7, 1, 0, 0, 0, LU);
        cyc("load_use_rd0", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, IDLE);
        cyc("no_load_match", 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, IDLE);
        cyc("pen3_c1", 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, PEN0);
        cyc("pen3_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, PEN1);
        cyc("pen3_c3", 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, PEN1);
        cyc("pen3_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("penb_c1", 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, PEN0);
        cyc("penb_busy1", 0, 0, 0, 0, 0, 0, 0, 1, 0, BUSY1);
        cyc("penb_busy2", 0, 0, 0, 0, 0, 0, 0, 1, 0, BUSY1);
        cyc("penb_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, PEN1);
        cyc("penb_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, PEN1);
        cyc("penb_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("pen1_c1", 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, PEN0);
        cyc("pen1_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("pen0_none", 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("branch_lu", 0, 0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, BR);
        cyc("branch_pen", 1, 2'd3, 0, 0, 0, 0, 1, 0, 0, BR);
        cyc("branch_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("branch_busy", 0, 0, 0, 0, 0, 0, 1, 1, 0, BUSY0);
        cyc("branch_unbusy", 0, 0, 0, 0, 0, 0, 1, 0, 0, BR);
        cyc("branch_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("exp_pen_c1", 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, PEN0);
        cyc("exp_in_pen", 0, 0, 0, 0, 0, 0, 0, 0, 1, ACK1);
        cyc("exp_in_trap", 0, 0, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, TRAPST);
        cyc("trap_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("pen_abandoned", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        cyc("exp_in_run", 0, 0, 0, 0, 0, 0, 0, 0, 1, ACK0);
        cyc("trap_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, TRAPST);
        rstn_i = 1'b0;
        #1 chk("async_reset_mid_trap", IDLE);
        @(posedge clk_i); #1 chk("reset_hold_trap", IDLE);
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1 chk("release_no_ack", IDLE);
        cyc("after_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
